// File: rtl/pcie_consts.sv
// Shared constants and record types for the PCIe queue-management tables.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcie_consts;

  // Index width of every queue-state BRAM table.
  localparam int BRAM_TABLE_IDX_WIDTH = 10;

  // Default widths of the queue-table accessor records.
  localparam int QT_DATA_WIDTH = 32;
  localparam int QT_TAG_WIDTH  = 8;

  // Lookup side-band carried alongside a read.
  typedef struct packed {
    logic [BRAM_TABLE_IDX_WIDTH-1:0] addr;
    logic [QT_TAG_WIDTH-1:0]         tag;
  } qt_lookup_meta_t;

  // One lookup response as held in the response FIFO.
  typedef struct packed {
    logic [BRAM_TABLE_IDX_WIDTH-1:0] addr;
    logic [QT_DATA_WIDTH-1:0]        data;
    logic [QT_TAG_WIDTH-1:0]         tag;
  } qt_resp_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int qt_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_interface_io.sv
// User/owner connection to a single-port table BRAM.
// Latency: rd_data is valid RD_LATENCY cycles after the cycle rd_en is driven.
// Backpressure: none; the owner accepts one access per cycle.
interface bram_interface_io
  import pcie_consts::*;
#(
  parameter int ADDR_WIDTH = BRAM_TABLE_IDX_WIDTH,
  parameter int DATA_WIDTH = 32
);

  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport user  (output rd_en, wr_en, addr, wr_data, input  rd_data);
  modport owner (input  rd_en, wr_en, addr, wr_data, output rd_data);

endinterface

// File: rtl/queue_table_resp_fifo.sv
// First-word-fall-through response FIFO with an occupancy count for credit checks.
// Latency: an entry pushed at a clock edge is visible on out_* right after that edge.
// Backpressure: out_rdy holds the head; the writer must never push while full.
module queue_table_resp_fifo
  import pcie_consts::*;
#(
  parameter type entry_t = qt_resp_t,
  parameter int  DEPTH   = 8,
  parameter int  CW      = qt_cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  entry_t        push_dat,
  output logic          out_vld,
  output entry_t        out_dat,
  input  logic          out_rdy,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  // Next pointer/count values; push and pop together leave the count unchanged.
  always_comb begin
    pop      = (count_q != '0) && out_rdy;
    wr_ptr_d = wr_ptr_q + PW'(push_vld);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_vld) - CW'(pop);
  end

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_vld = (count_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/queue_table_accessor.sv
// Merges table lookups and pointer updates onto one BRAM port, forwarding in-flight writes.
// Latency: response appears 1 + RD_LATENCY + 1 cycles after the lookup handshake cycle.
// Backpressure: lookup_ready drops on any update or when in-flight reads plus FIFO fill reach OUT_DEPTH.
module queue_table_accessor
  import pcie_consts::*;
#(
  parameter int ADDR_WIDTH = BRAM_TABLE_IDX_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int RD_LATENCY = 2,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  lookup_ready,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_data,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  input  logic                  resp_ready,
  bram_interface_io.user        bram
);

  localparam int CW = qt_cnt_width(OUT_DEPTH);
  localparam int SW = CW + 1;

  // One slot of the read pipeline; fwd_* capture writes that land after the BRAM read.
  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
  } stage_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } resp_t;

  // Registered BRAM drive plus the tag of the read currently presented.
  logic                  run_q;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [TAG_WIDTH-1:0]  iss_tag_q, iss_tag_d;

  stage_t                pipe_q [RD_LATENCY];
  stage_t                pipe_d [RD_LATENCY];
  stage_t                src    [RD_LATENCY];

  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         credit_sum;
  logic                  credit_ok;
  logic                  accept;

  stage_t                exit_stage;
  logic                  push_vld;
  resp_t                 push_dat;
  resp_t                 head;

  // Credit rule: every accepted read already owns a FIFO slot, so the FIFO cannot overflow.
  always_comb begin
    credit_sum = SW'(inflight_q) + SW'(fifo_count);
    credit_ok  = credit_sum < SW'(OUT_DEPTH);
  end

  assign lookup_ready = run_q && !upd_valid && credit_ok;
  assign accept       = lookup_valid && lookup_ready;

  // Port arbitration: updates always win; address/data hold their last value when idle.
  always_comb begin
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    iss_tag_d = iss_tag_q;
    if (upd_valid) begin
      wr_en_d   = 1'b1;
      addr_d    = upd_addr;
      wr_data_d = upd_data;
    end else if (accept) begin
      rd_en_d   = 1'b1;
      addr_d    = lookup_addr;
      iss_tag_d = lookup_tag;
    end
  end

  // Advance the read pipeline, latching any update that targets a read already sent to the BRAM.
  always_comb begin
    src[0] = '{vld: rd_en_q, addr: addr_q, tag: iss_tag_q, fwd_hit: 1'b0, fwd_data: '0};
    for (int k = 1; k < RD_LATENCY; k++) begin
      src[k] = pipe_q[k-1];
    end
    for (int k = 0; k < RD_LATENCY; k++) begin
      pipe_d[k] = src[k];
      if (src[k].vld && upd_valid && (src[k].addr == upd_addr)) begin
        pipe_d[k].fwd_hit  = 1'b1;
        pipe_d[k].fwd_data = upd_data;
      end
    end
  end

  // Pipeline exit: forwarded data overrides the stale BRAM value.
  always_comb begin
    exit_stage    = pipe_q[RD_LATENCY-1];
    push_vld      = exit_stage.vld;
    push_dat.addr = exit_stage.addr;
    push_dat.tag  = exit_stage.tag;
    push_dat.data = exit_stage.fwd_hit ? exit_stage.fwd_data : bram.rd_data;
  end

  // Reads issued but not yet written into the FIFO.
  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(push_vld);
  end

  // BRAM drive registers and the post-reset enable for lookup_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      iss_tag_q <= '0;
    end else begin
      run_q     <= 1'b1;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      iss_tag_q <= iss_tag_d;
    end
  end

  // Read pipeline registers; reset discards every read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  // In-flight read counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign bram.rd_en   = rd_en_q;
  assign bram.wr_en   = wr_en_q;
  assign bram.addr    = addr_q;
  assign bram.wr_data = wr_data_q;

  queue_table_resp_fifo #(
    .entry_t (resp_t),
    .DEPTH   (OUT_DEPTH),
    .CW      (CW)
  ) u_resp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .out_vld  (resp_valid),
    .out_dat  (head),
    .out_rdy  (resp_ready),
    .count    (fifo_count)
  );

  assign resp_addr = head.addr;
  assign resp_data = head.data;
  assign resp_tag  = head.tag;

endmodule

// File: tb/tb_queue_table_accessor.sv
// Randomized scoreboard bench for queue_table_accessor with a behavioural BRAM.
// Latency: expected responses snapshot the table RD_LATENCY cycles after acceptance.
// Backpressure: resp_ready is toggled and held low to fill the response FIFO.
module tb_queue_table_accessor;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int TW    = 8;
  localparam int L     = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_valid = 1'b0;
  logic [AW-1:0] lookup_addr = '0;
  logic [TW-1:0] lookup_tag = '0;
  logic          lookup_ready;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_addr = '0;
  logic [DW-1:0] upd_data = '0;
  logic          resp_valid;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_ready = 1'b0;

  always #5 clk = ~clk;

  bram_interface_io #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bram_if ();

  queue_table_accessor #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .RD_LATENCY (L),
    .OUT_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_addr  (lookup_addr),
    .lookup_tag   (lookup_tag),
    .lookup_ready (lookup_ready),
    .upd_valid    (upd_valid),
    .upd_addr     (upd_addr),
    .upd_data     (upd_data),
    .resp_valid   (resp_valid),
    .resp_addr    (resp_addr),
    .resp_data    (resp_data),
    .resp_tag     (resp_tag),
    .resp_ready   (resp_ready),
    .bram         (bram_if)
  );

  // Behavioural BRAM: a read driven in cycle c returns data in cycle c+L.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rdq [L];
  always @(posedge clk) begin
    if (bram_if.wr_en) mem[bram_if.addr] <= bram_if.wr_data;
    rdq[0] <= bram_if.rd_en ? mem[bram_if.addr] : 32'hDEAD_BEEF;
    for (int k = 1; k < L; k++) rdq[k] <= rdq[k-1];
  end
  assign bram_if.rd_data = rdq[L-1];

  // Reference model: a table updated when an update is presented; a lookup
  // accepted in cycle a reports the table as it stands after cycle a+L.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [TW-1:0] tag; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag; int cap; } pend_t;

  exp_t          exp_q [$];
  pend_t         pend_q [$];
  logic [DW-1:0] tbl [16];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit lv, input logic [AW-1:0] la, input logic [TW-1:0] lt,
                      input bit uv, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                      input bit rr, output bit acc, output bit rv);
    pend_t p;
    exp_t  e;
    @(negedge clk);
    lookup_valid = lv; lookup_addr = la; lookup_tag = lt;
    upd_valid = uv; upd_addr = ua; upd_data = ud;
    resp_ready = rr;
    #1;
    acc = lv && lookup_ready;
    rv  = resp_valid;
    cyc++;
    if (uv) tbl[ua[3:0]] = ud;
    if (acc) begin
      p.addr = la; p.tag = lt; p.cap = cyc + L;
      pend_q.push_back(p);
    end
    while (pend_q.size() > 0 && pend_q[0].cap <= cyc) begin
      p = pend_q.pop_front();
      e.addr = p.addr; e.data = tbl[p.addr[3:0]]; e.tag = p.tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input bit rr, output bit rv);
    bit a;
    step(1'b0, '0, '0, 1'b0, '0, '0, rr, a, rv);
  endtask

  task automatic drain(input string name);
    bit v;
    int n = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 200) begin
      idle(1'b1, v);
      n++;
    end
    idle(1'b1, v);
    chk(name, 64'(exp_q.size() + pend_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      chk("rd_wr_exclusive", {63'd0, bram_if.rd_en & bram_if.wr_en}, 64'd0);
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_resp: got addr %0h data %0h tag %0h, expected no response",
                   resp_addr, resp_data, resp_tag);
        end else begin
          e = exp_q.pop_front();
          chk("resp_addr", 64'(resp_addr), 64'(e.addr));
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_tag",  64'(resp_tag),  64'(e.tag));
        end
      end
    end
  end

  initial begin
    bit a, v;
    int n;

    // Reset state
    #12;
    chk("rst_lookup_ready", 64'(lookup_ready), 64'd0);
    chk("rst_resp_valid",   64'(resp_valid),   64'd0);
    chk("rst_rd_en",        64'(bram_if.rd_en), 64'd0);
    chk("rst_wr_en",        64'(bram_if.wr_en), 64'd0);
    chk("rst_addr",         64'(bram_if.addr), 64'd0);
    chk("rst_wr_data",      64'(bram_if.wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload the first 16 entries through the update port
    for (int i = 0; i < 16; i++)
      step(1'b0, '0, '0, 1'b1, AW'(i), 32'h1000_0000 + 32'(i * 7), 1'b1, a, v);
    step(1'b0, '0, '0, 1'b1, AW'(5), 32'hA5A5_0001, 1'b1, a, v);
    for (int i = 0; i < 3; i++) idle(1'b1, v);

    // Single lookup latency
    step(1'b1, AW'(5), TW'(3), 1'b0, '0, '0, 1'b1, a, v);
    chk("lat_accept", 64'(a), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1, v);
      chk($sformatf("lat_resp_valid_cyc%0d", i), 64'(v), 64'(i == 4));
    end
    drain("drain_latency");

    // Forwarding of one update, then of two updates, during flight
    step(1'b1, AW'(7), TW'(8'h11), 1'b0, '0, '0, 1'b1, a, v);
    step(1'b0, '0, '0, 1'b1, AW'(7), 32'h0000_1234, 1'b1, a, v);
    drain("drain_fwd1");
    step(1'b1, AW'(7), TW'(8'h12), 1'b0, '0, '0, 1'b1, a, v);
    step(1'b0, '0, '0, 1'b1, AW'(7), 32'h1, 1'b1, a, v);
    step(1'b0, '0, '0, 1'b1, AW'(7), 32'h2, 1'b1, a, v);
    drain("drain_fwd2");

    // Fill the FIFO with resp_ready low
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, AW'(i), TW'(8'h40 + i), 1'b0, '0, '0, 1'b0, a, v);
      n += int'(a);
    end
    chk("full_accept_count", 64'(n), 64'(DEPTH));
    chk("full_ready_low", 64'(lookup_ready), 64'd0);
    drain("drain_full");

    // Updates block lookups; only writes reach the BRAM meanwhile
    for (int i = 0; i < 3; i++) begin
      step(1'b1, AW'(9), TW'(8'h55), 1'b1, AW'(3), 32'h300 + 32'(i), 1'b1, a, v);
      chk($sformatf("upd_block_acc%0d", i), 64'(a), 64'd0);
      chk($sformatf("upd_block_rd_en%0d", i), 64'(bram_if.rd_en), 64'd0);
      if (i > 0) chk($sformatf("upd_block_wr_en%0d", i), 64'(bram_if.wr_en), 64'd1);
    end
    step(1'b1, AW'(9), TW'(8'h55), 1'b0, '0, '0, 1'b1, a, v);
    chk("upd_then_accept", 64'(a), 64'd1);
    idle(1'b1, v);
    chk("upd_then_rd_en", 64'(bram_if.rd_en), 64'd1);
    chk("upd_then_wr_en", 64'(bram_if.wr_en), 64'd0);
    chk("upd_then_addr",  64'(bram_if.addr), 64'd9);
    drain("drain_upd");

    // Reset with reads in flight and responses in the FIFO
    for (int i = 0; i < 6; i++)
      step(1'b1, AW'(i), TW'(8'h60 + i), 1'b0, '0, '0, 1'b0, a, v);
    idle(1'b0, v);
    chk("pre_reset_resp_valid", 64'(resp_valid), 64'd1);
    chk("pre_reset_rd_en", 64'(bram_if.rd_en), 64'd1);
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    #1;
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_rd_en", 64'(bram_if.rd_en), 64'd0);
    chk("reset_lookup_ready", 64'(lookup_ready), 64'd0);
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) idle(1'b1, v);
    step(1'b1, AW'(2), TW'(8'h77), 1'b0, '0, '0, 1'b1, a, v);
    chk("post_reset_accept", 64'(a), 64'd1);
    drain("drain_reset");

    // Randomized mix of lookups, updates and backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, AW'($urandom_range(0, 15)), TW'($urandom),
           $urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)), 32'($urandom),
           $urandom_range(0, 3) != 0, a, v);
    end
    drain("drain_final");

    idle(1'b1, v);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
